// File: rtl/rv32i_ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I control FSM.
// State enum, opcodes, ALU codes and datapath select encodings.
package rv32i_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTER,
    S_EXECUTEI,
    S_LUI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_ILLEGAL
  } state_t;

  localparam state_t RESET_STATE = S_FETCH;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_ZERO = 3'b111;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] imm_src;
    logic [2:0] alu_control;
    logic       illegal_instr;
  } ctrl_t;

  function automatic logic [2:0] imm_sel(input logic [6:0] op);
    unique case (op)
      OP_STORE:  return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_JAL:    return IMM_J;
      OP_LUI:    return IMM_U;
      default:   return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// Combinational ALU op decode for R-type and I-type arithmetic.
// funct_valid is low for unsupported funct3 of those two opcodes.
module alu_decoder
  import rv32i_ctrl_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  output logic [2:0] alu_control_o,
  output logic       funct_valid_o
);

  logic is_r;
  logic is_arith;

  assign is_r     = (opcode_i == OP_R);
  assign is_arith = is_r || (opcode_i == OP_I);

  // Map funct3/funct7b5 to ALU op; non-arith opcodes default to add.
  always_comb begin
    alu_control_o = ALU_ADD;
    funct_valid_o = 1'b1;
    if (is_arith) begin
      unique case (funct3_i)
        3'b000: alu_control_o =
                  (is_r && funct7b5_i) ? ALU_SUB : ALU_ADD;
        3'b111: alu_control_o = ALU_AND;
        3'b110: alu_control_o = ALU_OR;
        default: funct_valid_o = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle RV32I datapath.
// Drives ALU op, operand/imm selects and all write enables.
module multicycle_ctrl
  import rv32i_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       last_bit,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] imm_src,
  output logic [2:0] alu_control,
  output logic       illegal_instr
);

  state_t     state_q, state_d;
  logic [2:0] dec_alu;
  logic       funct_ok;
  logic       br_ok;
  logic       taken;
  logic       is_mem;
  ctrl_t      c;

  alu_decoder u_dec (
    .opcode_i      (opcode),
    .funct3_i      (funct3),
    .funct7b5_i    (funct7b5),
    .alu_control_o (dec_alu),
    .funct_valid_o (funct_ok)
  );

  assign is_mem = (opcode == OP_LOAD) || (opcode == OP_STORE);

  // Branch condition from ALU flags; blt/bge use raw sign bit.
  always_comb begin
    br_ok = 1'b1;
    taken = 1'b0;
    unique case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = !zero;
      3'b100:  taken = last_bit;
      3'b101:  taken = !last_bit;
      default: br_ok = 1'b0;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:
        if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          is_mem:
            state_d = (funct3 == 3'b010) ? S_MEMADR : S_ILLEGAL;
          opcode == OP_R:
            state_d = funct_ok ? S_EXECUTER : S_ILLEGAL;
          opcode == OP_I:
            state_d = funct_ok ? S_EXECUTEI : S_ILLEGAL;
          opcode == OP_LUI:
            state_d = S_LUI;
          opcode == OP_BRANCH:
            state_d = br_ok ? S_BRANCH : S_ILLEGAL;
          opcode == OP_JAL:
            state_d = S_JAL;
          default:
            state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR:
        state_d = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:
        if (mem_ready) state_d = S_MEMWB;
      S_MEMWRITE:
        if (mem_ready) state_d = S_FETCH;
      S_EXECUTER, S_EXECUTEI, S_LUI, S_JAL:
        state_d = S_ALUWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_ILLEGAL:
        state_d = S_FETCH;
      default:
        state_d = S_FETCH;
    endcase
  end

  // State register; reset lands in FETCH immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RESET_STATE;
    else        state_q <= state_d;
  end

  // Per-state control word; reset forces every output low.
  always_comb begin
    c = '0;
    unique case (state_q)
      S_FETCH: begin
        c.mem_req    = 1'b1;
        c.alu_src_a  = SRCA_PC;
        c.alu_src_b  = SRCB_FOUR;
        c.result_src = RES_ALU;
        c.ir_write   = mem_ready;
        c.pc_write   = mem_ready;
      end
      S_DECODE: begin
        c.alu_src_a = SRCA_OLDPC;
        c.alu_src_b = SRCB_IMM;
        c.imm_src   = imm_sel(opcode);
      end
      S_MEMADR: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_IMM;
        c.imm_src   = imm_sel(opcode);
      end
      S_MEMREAD: begin
        c.mem_req = 1'b1;
        c.adr_src = 1'b1;
      end
      S_MEMWB: begin
        c.result_src = RES_MEM;
        c.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        c.mem_req   = 1'b1;
        c.mem_write = 1'b1;
        c.adr_src   = 1'b1;
      end
      S_EXECUTER: begin
        c.alu_src_a   = SRCA_RS1;
        c.alu_src_b   = SRCB_RS2;
        c.alu_control = dec_alu;
      end
      S_EXECUTEI: begin
        c.alu_src_a   = SRCA_RS1;
        c.alu_src_b   = SRCB_IMM;
        c.imm_src     = imm_sel(opcode);
        c.alu_control = dec_alu;
      end
      S_LUI: begin
        c.alu_src_a = SRCA_ZERO;
        c.alu_src_b = SRCB_IMM;
        c.imm_src   = IMM_U;
      end
      S_ALUWB: begin
        c.result_src = RES_ALUOUT;
        c.reg_write  = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a   = SRCA_RS1;
        c.alu_src_b   = SRCB_RS2;
        c.alu_control = ALU_SUB;
        c.result_src  = RES_ALUOUT;
        c.pc_write    = taken;
      end
      S_JAL: begin
        c.alu_src_a  = SRCA_OLDPC;
        c.alu_src_b  = SRCB_FOUR;
        c.result_src = RES_ALUOUT;
        c.pc_write   = 1'b1;
      end
      S_ILLEGAL:
        c.illegal_instr = 1'b1;
      default: ;
    endcase
    if (!rst_n) c = '0;
  end

  assign mem_req       = c.mem_req;
  assign mem_write     = c.mem_write;
  assign adr_src       = c.adr_src;
  assign ir_write      = c.ir_write;
  assign pc_write      = c.pc_write;
  assign reg_write     = c.reg_write;
  assign result_src    = c.result_src;
  assign alu_src_a     = c.alu_src_a;
  assign alu_src_b     = c.alu_src_b;
  assign imm_src       = c.imm_src;
  assign alu_control   = c.alu_control;
  assign illegal_instr = c.illegal_instr;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl.
// Per-cycle expected control words are built from hand-picked constants.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic       req;
    logic       wr;
    logic       adr;
    logic       irw;
    logic       pcw;
    logic       regw;
    logic [1:0] rs;
    logic [1:0] a;
    logic [1:0] b;
    logic [2:0] imm;
    logic [2:0] alu;
    logic       ill;
  } o_t;

  logic       clk;
  logic       rst_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       last_bit;
  logic       mem_ready;
  logic       mem_req, mem_write, adr_src;
  logic       ir_write, pc_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] imm_src, alu_control;
  logic       illegal_instr;
  o_t         outs;

  int total = 0;
  int bad   = 0;

  multicycle_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .opcode        (opcode),
    .funct3        (funct3),
    .funct7b5      (funct7b5),
    .zero          (zero),
    .last_bit      (last_bit),
    .mem_ready     (mem_ready),
    .mem_req       (mem_req),
    .mem_write     (mem_write),
    .adr_src       (adr_src),
    .ir_write      (ir_write),
    .pc_write      (pc_write),
    .reg_write     (reg_write),
    .result_src    (result_src),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .imm_src       (imm_src),
    .alu_control   (alu_control),
    .illegal_instr (illegal_instr)
  );

  assign outs = {mem_req, mem_write, adr_src, ir_write, pc_write,
                 reg_write, result_src, alu_src_a, alu_src_b,
                 imm_src, alu_control, illegal_instr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic o_t mk(
    input logic req, wr, adr, irw, pcw, regw,
    input logic [1:0] rs, a, b,
    input logic [2:0] imm, alu,
    input logic ill);
    return {req, wr, adr, irw, pcw, regw, rs, a, b, imm, alu, ill};
  endfunction

  localparam logic L = 1'b0;
  localparam logic H = 1'b1;

  function automatic o_t e_fetch(input logic rdy);
    return mk(H, L, L, rdy, rdy, L, 2'b10, 2'b00, 2'b10,
              3'b000, 3'b000, L);
  endfunction
  function automatic o_t e_dec(input logic [2:0] imm);
    return mk(L, L, L, L, L, L, 2'b00, 2'b01, 2'b01, imm, 3'b000, L);
  endfunction
  function automatic o_t e_memadr(input logic [2:0] imm);
    return mk(L, L, L, L, L, L, 2'b00, 2'b10, 2'b01, imm, 3'b000, L);
  endfunction
  function automatic o_t e_exr(input logic [2:0] alu);
    return mk(L, L, L, L, L, L, 2'b00, 2'b10, 2'b00, 3'b000, alu, L);
  endfunction
  function automatic o_t e_exi(input logic [2:0] alu);
    return mk(L, L, L, L, L, L, 2'b00, 2'b10, 2'b01, 3'b000, alu, L);
  endfunction
  function automatic o_t e_lui();
    return mk(L, L, L, L, L, L, 2'b00, 2'b11, 2'b01, 3'b100, 3'b000, L);
  endfunction
  function automatic o_t e_aluwb();
    return mk(L, L, L, L, L, H, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, L);
  endfunction
  function automatic o_t e_memrd();
    return mk(H, L, H, L, L, L, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, L);
  endfunction
  function automatic o_t e_memwb();
    return mk(L, L, L, L, L, H, 2'b01, 2'b00, 2'b00, 3'b000, 3'b000, L);
  endfunction
  function automatic o_t e_memwr();
    return mk(H, H, H, L, L, L, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, L);
  endfunction
  function automatic o_t e_br(input logic tk);
    return mk(L, L, L, L, tk, L, 2'b00, 2'b10, 2'b00, 3'b000, 3'b001, L);
  endfunction
  function automatic o_t e_jal();
    return mk(L, L, L, L, H, L, 2'b00, 2'b01, 2'b10, 3'b000, 3'b000, L);
  endfunction
  function automatic o_t e_ill();
    return mk(L, L, L, L, L, L, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, H);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    o_t z;
    z = '0;
    rst_n = 1'b0; mem_ready = 1'b1;
    opcode = 7'b0; funct3 = 3'b0; funct7b5 = 1'b0;
    zero = 1'b0; last_bit = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick(); #1;
      total++;
      if (outs !== z) begin
        bad++;
        $display("FAIL reset_low cyc%0d got=%h exp=%h", i, outs, z);
      end
    end
    rst_n = 1'b1; #1;
    total++;
    if (outs !== e_fetch(H)) begin
      bad++;
      $display("FAIL reset_fetch got=%h exp=%h", outs, e_fetch(H));
    end
    mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++;
      if (outs !== e_fetch(L)) begin
        bad++;
        $display("FAIL reset_hold cyc%0d got=%h exp=%h",
                 i, outs, e_fetch(L));
      end
      tick();
    end
  endtask

  task automatic test_rtype();
    o_t   e[5];
    logic r[5];
    opcode = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1;
    e = '{e_fetch(H), e_dec(3'b000), e_exr(3'b001),
          e_aluwb(), e_fetch(L)};
    r = '{H, L, L, L, L};
    for (int i = 0; i < 5; i++) begin
      mem_ready = r[i]; #1;
      total++;
      if (outs !== e[i]) begin
        bad++;
        $display("FAIL rtype_sub cyc%0d got=%h exp=%h", i, outs, e[i]);
      end
      tick();
    end
  endtask

  task automatic test_itype_lui();
    o_t   e[5];
    logic r[5];
    opcode = 7'b0010011; funct3 = 3'b110; funct7b5 = 1'b1;
    e = '{e_fetch(H), e_dec(3'b000), e_exi(3'b011),
          e_aluwb(), e_fetch(L)};
    r = '{H, L, L, L, L};
    for (int i = 0; i < 5; i++) begin
      mem_ready = r[i]; #1;
      total++;
      if (outs !== e[i]) begin
        bad++;
        $display("FAIL itype_or cyc%0d got=%h exp=%h", i, outs, e[i]);
      end
      tick();
    end
    opcode = 7'b0110111; funct3 = 3'b011; funct7b5 = 1'b0;
    e = '{e_fetch(H), e_dec(3'b100), e_lui(),
          e_aluwb(), e_fetch(L)};
    for (int i = 0; i < 5; i++) begin
      mem_ready = r[i]; #1;
      total++;
      if (outs !== e[i]) begin
        bad++;
        $display("FAIL lui cyc%0d got=%h exp=%h", i, outs, e[i]);
      end
      tick();
    end
  endtask

  task automatic test_load_wait();
    o_t   e[9];
    logic r[9];
    opcode = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0;
    e = '{e_fetch(H), e_dec(3'b000), e_memadr(3'b000),
          e_memrd(), e_memrd(), e_memrd(), e_memrd(),
          e_memwb(), e_fetch(L)};
    r = '{H, H, H, L, L, L, H, H, L};
    for (int i = 0; i < 9; i++) begin
      mem_ready = r[i]; #1;
      total++;
      if (outs !== e[i]) begin
        bad++;
        $display("FAIL lw_wait cyc%0d got=%h exp=%h", i, outs, e[i]);
      end
      tick();
    end
  endtask

  task automatic test_store();
    o_t   e[5];
    logic r[5];
    opcode = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0;
    e = '{e_fetch(H), e_dec(3'b001), e_memadr(3'b001),
          e_memwr(), e_fetch(L)};
    r = '{H, L, L, H, L};
    for (int i = 0; i < 5; i++) begin
      mem_ready = r[i]; #1;
      total++;
      if (outs !== e[i]) begin
        bad++;
        $display("FAIL sw cyc%0d got=%h exp=%h", i, outs, e[i]);
      end
      tick();
    end
  endtask

  task automatic test_branch();
    logic [2:0] f3[5];
    logic       z[5];
    logic       lb[5];
    logic       tk[5];
    o_t         e[4];
    logic       r[4];
    f3 = '{3'b001, 3'b001, 3'b100, 3'b101, 3'b000};
    z  = '{L, H, L, L, H};
    lb = '{L, L, H, H, L};
    tk = '{H, L, H, L, H};
    r  = '{H, H, L, L};
    opcode = 7'b1100011; funct7b5 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      funct3 = f3[k]; zero = z[k]; last_bit = lb[k];
      e = '{e_fetch(H), e_dec(3'b010), e_br(tk[k]), e_fetch(L)};
      for (int i = 0; i < 4; i++) begin
        mem_ready = r[i]; #1;
        total++;
        if (outs !== e[i]) begin
          bad++;
          $display("FAIL branch%0d cyc%0d got=%h exp=%h",
                   k, i, outs, e[i]);
        end
        tick();
      end
    end
    zero = 1'b0; last_bit = 1'b0;
  endtask

  task automatic test_jal();
    o_t   e[5];
    logic r[5];
    opcode = 7'b1101111; funct3 = 3'b000; funct7b5 = 1'b0;
    e = '{e_fetch(H), e_dec(3'b011), e_jal(), e_aluwb(), e_fetch(L)};
    r = '{H, L, L, L, L};
    for (int i = 0; i < 5; i++) begin
      mem_ready = r[i]; #1;
      total++;
      if (outs !== e[i]) begin
        bad++;
        $display("FAIL jal cyc%0d got=%h exp=%h", i, outs, e[i]);
      end
      tick();
    end
  endtask

  task automatic test_illegal();
    logic [6:0] op[4];
    logic [2:0] f3[4];
    logic [2:0] im[4];
    o_t         e[4];
    logic       r[4];
    op = '{7'b0000000, 7'b0010011, 7'b1100011, 7'b0000011};
    f3 = '{3'b000, 3'b001, 3'b010, 3'b000};
    im = '{3'b000, 3'b000, 3'b010, 3'b000};
    r  = '{H, H, H, L};
    funct7b5 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      opcode = op[k]; funct3 = f3[k];
      e = '{e_fetch(H), e_dec(im[k]), e_ill(), e_fetch(L)};
      for (int i = 0; i < 4; i++) begin
        mem_ready = r[i]; #1;
        total++;
        if (outs !== e[i]) begin
          bad++;
          $display("FAIL illegal%0d cyc%0d got=%h exp=%h",
                   k, i, outs, e[i]);
        end
        tick();
      end
    end
  endtask

  task automatic test_store_reset();
    o_t   e[4];
    logic r[4];
    o_t   z;
    z = '0;
    opcode = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0;
    e = '{e_fetch(H), e_dec(3'b001), e_memadr(3'b001), e_memwr()};
    r = '{H, L, L, L};
    for (int i = 0; i < 4; i++) begin
      mem_ready = r[i]; #1;
      total++;
      if (outs !== e[i]) begin
        bad++;
        $display("FAIL sw_rst cyc%0d got=%h exp=%h", i, outs, e[i]);
      end
      if (i < 3) tick();
    end
    rst_n = 1'b0; #1;
    total++;
    if (outs !== z) begin
      bad++;
      $display("FAIL sw_rst_drop got=%h exp=%h", outs, z);
    end
    tick();
    rst_n = 1'b1; mem_ready = 1'b0; #1;
    total++;
    if (outs !== e_fetch(L)) begin
      bad++;
      $display("FAIL sw_rst_fetch got=%h exp=%h", outs, e_fetch(L));
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_itype_lui();
    test_load_wait();
    test_store();
    test_branch();
    test_jal();
    test_illegal();
    test_store_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Main control FSM for the multicycle RV32I datapath. It sits directly upstream of the ALU.
- Each cycle it drives alu_control, operand selects, immediate select and all write enables.
- It consumes the ALU flags zero and last_bit to resolve conditional branches.
- Memory accesses use a req/ready handshake so fetch and load/store tolerate wait states.

Parameters:
- RESET_STATE, FETCH, state entered on reset (fixed; exposed for bench visibility only).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset: asynchronous, active-low
- opcode  in  7  instruction register bits [6:0]
- funct3  in  3  instruction register bits [14:12]
- funct7b5  in  1  instruction register bit 30
- zero  in  1  ALU result == 0
- last_bit  in  1  ALU result bit 31
- mem_ready  in  1  memory completes current access this cycle
- mem_req  out  1  memory access request
- mem_write  out  1  store strobe, valid with mem_req
- adr_src  out  1  0 = PC, 1 = ALUOut
- ir_write  out  1  latch instruction and old PC
- pc_write  out  1  load PC from result bus
- reg_write  out  1  register file write enable
- result_src  out  2  00 ALUOut, 01 mem data, 10 ALU result
- alu_src_a  out  2  00 PC, 01 old PC, 10 rs1, 11 zero
- alu_src_b  out  2  00 rs2, 01 imm, 10 constant 4
- imm_src  out  3  000 I, 001 S, 010 B, 011 J, 100 U
- alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 111 zero
- illegal_instr  out  1  one-cycle pulse on unsupported encoding

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, LUI, ALUWB, BRANCH, JAL, ILLEGAL.
- Outputs are Moore-style from state and instruction fields, except the qualifications stated below.
- Outputs default to 0 in every state unless listed.
- Reset: rst_n low forces state FETCH immediately. While rst_n is low, all enables (mem_req, mem_write, ir_write, pc_write, reg_write, illegal_instr) are gated to 0 and all selects are 0.
- FETCH:
  - mem_req=1, adr_src=0, a=00, b=10, add, result_src=10.
  - When mem_ready: ir_write=1, pc_write=1, next DECODE. Otherwise hold FETCH with no writes.
- DECODE:
  - a=01, b=01, add (branch/jump target into ALUOut). imm_src from opcode.
  - Next state by opcode:
    - 0000011 lw or 0100011 sw (funct3 must be 010) -> MEMADR.
    - 0110011 -> EXECUTER.
    - 0010011 -> EXECUTEI.
    - 0110111 -> LUI.
    - 1100011 -> BRANCH.
    - 1101111 -> JAL.
    - Any other opcode or unsupported funct3 -> ILLEGAL.
- MEMADR: a=10, b=01, add. lw -> MEMREAD; sw -> MEMWRITE.
- MEMREAD: mem_req=1, adr_src=1. When mem_ready -> MEMWB; otherwise stay.
- MEMWB: result_src=01, reg_write=1 -> FETCH.
- MEMWRITE: mem_req=1, mem_write=1, adr_src=1, both held stable while waiting. When mem_ready -> FETCH.
- EXECUTER: a=10, b=00, ALU op per decode -> ALUWB.
- EXECUTEI: a=10, b=01, ALU op per decode -> ALUWB.
- LUI: a=11, b=01, imm_src=100, add -> ALUWB.
- ALUWB: result_src=00, reg_write=1 -> FETCH.
- BRANCH:
  - a=10, b=00, sub, result_src=00.
  - pc_write = taken, where taken is: beq(000) zero; bne(001) !zero; blt(100) last_bit; bge(101) !last_bit.
  - blt/bge ignore signed overflow.
  - Next FETCH.
- JAL: a=01, b=10, add, result_src=00, pc_write=1 -> ALUWB.
- ILLEGAL: illegal_instr=1 for exactly one cycle, no writes -> FETCH.
- ALU decode:
  - R-type: 000 gives add, or sub if funct7b5=1; 111 and; 110 or.
  - I-type: 000 add; 111 and; 110 or. funct7b5 is ignored.
  - Any other funct3 -> ILLEGAL.
- Write-enable exclusivity: pc_write and ir_write are never asserted outside FETCH/BRANCH/JAL. reg_write is asserted only in MEMWB/ALUWB.
- mem_ready outside FETCH/MEMREAD/MEMWRITE is ignored.
- Reset asserted mid-wait (e.g. in MEMWRITE) drops mem_req/mem_write immediately.
- Fixed cycle counts (zero-wait memory):
  - R/I/LUI: 4
  - lw: 5
  - sw: 4
  - branch: 3
  - jal: 4

Decomposition:
- Package rv32i_ctrl_pkg holds:
  - state enum;
  - opcode localparams;
  - alu_control constants (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_ZERO);
  - select encodings for result_src, alu_src_a, alu_src_b and imm_src.
- One sub-module, alu_decoder, is combinational: opcode/funct3/funct7b5 in, alu_control and a funct_valid flag out.

Test Plan:
- Reset: rst_n=0 with mem_ready=1 -> all enables 0. rst_n=1 -> FETCH with mem_req=1, ir_write=pc_write=1 on the first mem_ready.
- R-type opcode 0110011, funct3 000, funct7b5=1 -> EXECUTER alu_control=001, ALUWB reg_write=1, total 4 cycles, back in FETCH.
- lw with mem_ready low 3 cycles in MEMREAD -> mem_req/adr_src=1 held 4 cycles, then MEMWB result_src=01, reg_write=1.
- BRANCH: bne with zero=0 -> pc_write=1; bne with zero=1 -> pc_write=0. blt with last_bit=1 -> pc_write=1.
- Illegal encodings: opcode 0000000, or I-type funct3 001 -> illegal_instr high exactly 1 cycle, no reg_write/pc_write, then FETCH.
- Mid-store reset: rst_n low for 1 cycle while in MEMWRITE -> mem_write drops same cycle, state FETCH after release.
